// File: rtl/btn_pkg.sv
// Shared definitions for the push-button event decoder: FSM state encoding,
// event codes, and the width helpers used to size the tick counters.
package btn_pkg;

   // Decoder FSM states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRESS1 = 3'd1,
      WAIT2  = 3'd2,
      PRESS2 = 3'd3,
      LONG   = 3'd4
   } btn_state_t;

   // Event codes produced by the next-state logic; at most one per cycle
   typedef logic [2:0] evt_code_t;

   localparam evt_code_t EVT_NONE   = 3'd0;
   localparam evt_code_t EVT_SHORT  = 3'd1;
   localparam evt_code_t EVT_LONG   = 3'd2;
   localparam evt_code_t EVT_DCLICK = 3'd3;
   localparam evt_code_t EVT_REPEAT = 3'd4;

   // Bits needed to hold values 0..v-1
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // One-hot pulse vector {repeat, double, long, short} for an event code
   function automatic logic [3:0] evt_to_vec(input evt_code_t e);
      logic [3:0] v;
      v = 4'b0000;
      case (e)
         EVT_SHORT:  v = 4'b0001;
         EVT_LONG:   v = 4'b0010;
         EVT_DCLICK: v = 4'b0100;
         EVT_REPEAT: v = 4'b1000;
         default:    v = 4'b0000;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/btn_event_decoder_tick_gen.sv
// btn_tick_gen: restartable CLK_DIV prescaler. Counts 0..CLK_DIV-1 and
// fires tick on the terminal count; restart forces the count back to 0 so
// durations are measured from the most recent button edge. A tick that
// coincides with a restart is suppressed.
module btn_tick_gen
   import btn_pkg::*;
#(
   parameter int CLK_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int CW = clog2(CLK_DIV);

   logic [CW-1:0] r_cnt;
   logic          w_term;

   assign w_term = (r_cnt == CW'(CLK_DIV - 1));
   assign tick   = w_term & ~restart;

   // Prescaler count: restart on edges, wrap at the terminal count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (restart || w_term) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/btn_event_decoder.sv
// btn_event_decoder: turns the debounced button level into short-press,
// long-press and double-click pulses plus a running event count.
// Optional feature macro: BTN_REPEAT_EN adds auto-repeat pulses while the
// button is held in LONG; without it repeat_tick is tied low.
// dbg_state exposes the FSM state for observation.
module btn_event_decoder
   import btn_pkg::*;
#(
   parameter int CLK_DIV      = 50000,
   parameter int LONG_TICKS   = 1000,
   parameter int DCLICK_TICKS = 250,
   parameter int REPEAT_TICKS = 200,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             db,
   output logic             short_press,
   output logic             long_press,
   output logic             double_click,
   output logic             repeat_tick,
   output logic             held,
   output logic [CNT_W-1:0] evt_count,
   output logic [2:0]       dbg_state
);

   localparam int TCNT_W = clog2(max3(LONG_TICKS, DCLICK_TICKS, REPEAT_TICKS) + 1);

   logic              r_db_q;
   logic              w_rise;
   logic              w_fall;
   logic              w_tick;
   btn_state_t        r_state;
   btn_state_t        w_state_nxt;
   logic [TCNT_W-1:0] r_tcnt;
   logic              w_tcnt_clr;
   evt_code_t         w_evt;
   logic [3:0]        w_evt_vec;
   logic              r_short;
   logic              r_long;
   logic              r_dclick;
   logic              r_held;
   logic [CNT_W-1:0]  r_evt_count;

   assign w_rise    = db & ~r_db_q;
   assign w_fall    = ~db & r_db_q;
   assign w_evt_vec = evt_to_vec(w_evt);

   // Previous button level; resets high so a button held through reset is
   // not seen as a new press
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_db_q <= 1'b1;
      end else begin
         r_db_q <= db;
      end
   end

   btn_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk     (clk),
      .rst     (rst),
      .restart (w_rise | w_fall),
      .tick    (w_tick)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and event selection; edges are tested before ticks so an
   // edge always wins over a same-cycle tick
   always_comb begin
      w_state_nxt = r_state;
      w_evt       = EVT_NONE;
      w_tcnt_clr  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise) w_state_nxt = PRESS1;
         end
         PRESS1: begin
            if (w_fall) begin
               w_state_nxt = WAIT2;
            end else if (w_tick && r_tcnt == TCNT_W'(LONG_TICKS - 1)) begin
               w_state_nxt = LONG;
               w_evt       = EVT_LONG;
            end
         end
         WAIT2: begin
            if (w_rise) begin
               w_state_nxt = PRESS2;
               w_evt       = EVT_DCLICK;
            end else if (w_tick && r_tcnt == TCNT_W'(DCLICK_TICKS - 1)) begin
               w_state_nxt = IDLE;
               w_evt       = EVT_SHORT;
            end
         end
         PRESS2: begin
            if (w_fall) w_state_nxt = IDLE;
         end
         LONG: begin
            if (w_fall) begin
               w_state_nxt = IDLE;
`ifdef BTN_REPEAT_EN
            end else if (w_tick && r_tcnt == TCNT_W'(REPEAT_TICKS - 1)) begin
               w_evt      = EVT_REPEAT;
               w_tcnt_clr = 1'b1;
`endif
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Tick counter: cleared on every state change (and on each repeat),
   // otherwise advanced by the prescaler tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tcnt <= '0;
      end else if (w_state_nxt != r_state || w_tcnt_clr) begin
         r_tcnt <= '0;
      end else if (w_tick) begin
         r_tcnt <= r_tcnt + TCNT_W'(1);
      end
   end

   // Registered event pulses, held level and event count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_short     <= 1'b0;
         r_long      <= 1'b0;
         r_dclick    <= 1'b0;
         r_held      <= 1'b0;
         r_evt_count <= '0;
      end else begin
         r_short  <= w_evt_vec[0];
         r_long   <= w_evt_vec[1];
         r_dclick <= w_evt_vec[2];
         r_held   <= (w_state_nxt == LONG);
         if (|w_evt_vec) r_evt_count <= r_evt_count + CNT_W'(1);
      end
   end

`ifdef BTN_REPEAT_EN
   logic r_repeat;

   // Registered auto-repeat pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_repeat <= 1'b0;
      end else begin
         r_repeat <= w_evt_vec[3];
      end
   end

   assign repeat_tick = r_repeat;
`else
   assign repeat_tick = 1'b0;
`endif

   assign short_press  = r_short;
   assign long_press   = r_long;
   assign double_click = r_dclick;
   assign held         = r_held;
   assign evt_count    = r_evt_count;
   assign dbg_state    = r_state;

endmodule
